// File: rtl/mem_access_if.sv
// mem_access_if: load/store request, memory bus and result signals of mem_access
// master = mem_access (drives mem_*, stall, load results); slave = pipeline/memory side
interface mem_access_if;
  logic        MemRead, MemWrite;
  logic [2:0]  loadtype;
  logic [1:0]  storetype;
  logic [31:0] ALUresult, B;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, misalign, bus_err;
  modport master (
    input  MemRead, MemWrite, loadtype, storetype, ALUresult, B, mem_ready, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_data, load_valid, misalign, bus_err
  );
  modport slave (
    output MemRead, MemWrite, loadtype, storetype, ALUresult, B, mem_ready, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_data, load_valid, misalign, bus_err
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with lane formatting, load extension and timeout abort
// ports: clk, reset (sync, active-high), bus (mem_access_if.master: pipeline request, memory bus, results)
module mem_access #(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  mem_access_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, ld_q, ld_d, wd_d, ext;
  logic [3:0] be_q, be_d;
  logic [2:0] lt_q;
  logic [1:0] off_q;
  logic we_q, req, is_byte, is_half, mis, start;
  logic [7:0] rb;
  logic [15:0] rh;
  always_comb begin
    req = bus.MemRead | bus.MemWrite;
    // a simultaneous read+write is a store, so size comes from storetype
    is_byte = bus.MemWrite ? bus.storetype == 2'b01 : (bus.loadtype == 3'b001 || bus.loadtype == 3'b010);
    is_half = bus.MemWrite ? bus.storetype == 2'b10 : (bus.loadtype == 3'b011 || bus.loadtype == 3'b100);
    mis = state_q == IDLE && req && (is_half ? bus.ALUresult[0] : !is_byte && bus.ALUresult[1:0] != 2'b00);
    start = state_q == IDLE && req && !mis;
    be_d = is_byte ? 4'b0001 << bus.ALUresult[1:0] : is_half ? (bus.ALUresult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_d = is_byte ? {4{bus.B[7:0]}} : is_half ? {2{bus.B[15:0]}} : bus.B;
    rb = bus.mem_rdata[{off_q, 3'b000} +: 8];
    rh = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ext = lt_q == 3'b001 ? {{24{rb[7]}}, rb} :
          lt_q == 3'b010 ? {24'h0, rb} :
          lt_q == 3'b011 ? {{16{rh[15]}}, rh} :
          lt_q == 3'b100 ? {16'h0, rh} : bus.mem_rdata;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ld_d = ld_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d = 8'd0;
      end
      BUSY: if (bus.mem_ready) begin
        state_d = DONE;
        ld_d = we_q ? ld_q : ext;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = ERR;
        ld_d = 32'h0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      ld_q <= 32'h0;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      be_q <= 4'h0;
      lt_q <= 3'h0;
      off_q <= 2'h0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ld_q <= ld_d;
      if (start) begin
        addr_q <= {bus.ALUresult[31:2], 2'b00};
        wdata_q <= wd_d;
        be_q <= be_d;
        lt_q <= bus.loadtype;
        off_q <= bus.ALUresult[1:0];
        we_q <= bus.MemWrite;
      end
    end
  end
  always_comb begin
    bus.mem_req = state_q == BUSY;
    bus.mem_we = state_q == BUSY && we_q;
    bus.mem_be = state_q == BUSY ? be_q : 4'h0;
    bus.mem_addr = addr_q;
    bus.mem_wdata = wdata_q;
    bus.stall = start || state_q == BUSY;
    bus.load_data = ld_q;
    bus.load_valid = state_q == DONE && !we_q;
    bus.misalign = mis;
    bus.bus_err = state_q == ERR;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL be parameterised: TIMEOUT, default 15, maximum BUSY cycles to wait for mem_ready before aborting (legal range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request from the EX/MEM register.
- MemWrite  in  1  store request from the EX/MEM register.
- loadtype  in  3  load kind: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others treated as LW.
- storetype  in  2  store kind: 00 SW, 01 SB, 10 SH, 11 SW.
- ALUresult  in  32  byte address.
- B  in  32  store data, right-aligned.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address: {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables, little-endian (bit0 = byte 0).
- mem_wdata  out  32  lane-shifted store data.
- mem_ready  in  1  memory completion.
- mem_rdata  in  32  read word, valid with mem_ready.
- stall  out  1  holds the pipeline while an access is outstanding.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse: load_data valid.
- misalign  out  1  misaligned access detected; no memory access made.
- bus_err  out  1  one-cycle pulse: timeout abort.

Function
REQ-003 The FSM SHALL have four states: IDLE, BUSY, DONE and ERR.
REQ-004 In IDLE, the block SHALL define start = (MemRead | MemWrite) & ~misalign.
REQ-005 MemWrite SHALL take priority when MemRead and MemWrite are asserted together; the access is then a store.
REQ-006 misalign SHALL be combinational in IDLE only, under these conditions:
- word access with addr[1:0] != 0;
- half access with addr[0] != 0;
- byte access never.
REQ-007 A misaligned access SHALL leave the state unchanged, keep mem_req at 0 and keep stall at 0.
REQ-008 On start, the block SHALL register the following at the edge and enter BUSY: address, we, mem_be, mem_wdata, loadtype and addr[1:0].
REQ-009 stall SHALL equal start in IDLE, SHALL be 1 in BUSY, and SHALL be 0 in DONE and ERR.
REQ-010 In BUSY, mem_req SHALL be 1 and mem_addr, mem_we, mem_be and mem_wdata SHALL be driven from the registered values, held stable throughout.
REQ-011 In all other states, mem_req, mem_we and mem_be SHALL be 0.
REQ-012 In BUSY with mem_ready=1, the block SHALL enter DONE; for loads it SHALL register the extended mem_rdata into load_data at the same edge.
REQ-013 A 8-bit wait counter SHALL be cleared on entry to BUSY and SHALL increment each BUSY cycle without mem_ready.
REQ-014 When the counter reaches TIMEOUT-1 without mem_ready, the block SHALL enter ERR.
REQ-015 mem_ready in the same cycle as the timeout SHALL win, and the block SHALL go to DONE.
REQ-016 DONE SHALL last one cycle, with load_valid=1 for loads and 0 for stores, then return to IDLE.
REQ-017 No new start SHALL be accepted in DONE; the pipeline advances at that edge.
REQ-018 ERR SHALL last one cycle with bus_err=1 and load_data=0, then return to IDLE.
REQ-019 Store lane formatting SHALL be:
- SB: be = 1 << a[1:0], wdata = {4{B[7:0]}};
- SH: be = a[1] ? 1100 : 0011, wdata = {2{B[15:0]}};
- SW: be = 1111, wdata = B.
REQ-020 Load extraction SHALL be:
- LB/LBU: byte a[1:0] of rdata, sign- or zero-extended;
- LH/LHU: half a[1] of rdata, sign- or zero-extended;
- LW: rdata.
REQ-021 load_data SHALL hold its value until the next load completes or an ERR occurs.
REQ-022 mem_ready SHALL be ignored outside BUSY.

Reset
REQ-023 reset=1 at a clock edge SHALL force the following from the next cycle, regardless of state (including mid-BUSY):
- state IDLE;
- counter 0;
- load_data 0;
- mem_req, mem_we, mem_be, mem_wdata, mem_addr, stall, load_valid, bus_err and misalign all 0.
REQ-024 A mem_ready arriving in the same cycle as reset SHALL be discarded.

Verification
REQ-025 The bench SHALL cover SB: MemWrite=1, storetype=01, ALUresult=0x1003, B=0x000000A5, mem_ready on 2nd BUSY cycle -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, stall=1 for 3 cycles, no load_valid.
REQ-026 The bench SHALL cover LB: MemRead=1, loadtype=001, ALUresult=0x2002, mem_rdata=0x11F03344, ready after 1 cycle -> load_data=0xFFFFFFF0, load_valid pulse in DONE; LBU on the same data -> 0x000000F0.
REQ-027 The bench SHALL cover LH misaligned: loadtype=011, ALUresult=0x3001 -> misalign=1, mem_req never 1, stall=0, state stays IDLE.
REQ-028 The bench SHALL cover timeout: TIMEOUT=4, LW, mem_ready held 0 -> mem_req high exactly 4 cycles, then bus_err pulses 1 cycle with load_data=0, stall=0, then IDLE.
REQ-029 The bench SHALL cover reset mid-BUSY: LW in progress, reset asserted 1 cycle with mem_ready=1 -> next cycle all outputs 0, no load_valid, load_data=0.
REQ-030 The bench SHALL cover dual request: MemRead=MemWrite=1, storetype=00, ALUresult=0x40 -> store issued, mem_we=1, mem_be=1111, no load_valid.
